// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - opcodes and state encoding shared by the SPI flash responder
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser with rise/fall pulses on the synchronised level
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_flash_resp.sv
// rtl/spi_flash_resp.sv - mode-0 SPI flash target answering READ, RDID and RDSR
module spi_flash_resp
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int          ADDR_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_sck,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_busy
);

  logic w_sck, w_sck_rise, w_sck_fall;
  logic w_cs_n, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_sck),
    .o_q(w_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_cs_n),
    .o_q(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  state_t              r_state, w_next_state;
  logic                r_mosi_meta, r_mosi_sync;
  logic [1:0]          r_warm;
  logic                r_armed;
  logic                r_busy;
  logic [2:0]          r_bit_cnt;
  logic [1:0]          r_byte_cnt;
  logic [6:0]          r_shift;
  logic [23:0]         r_addr;
  logic [7:0]          r_cmd;
  logic [7:0]          r_tx;
  logic                r_miso;
  logic                r_rd;
  logic                r_rd_d;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          w_cmd_byte;
  logic [23:0]         w_addr_full;
  logic [1:0]          w_id_next;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

  assign w_cmd_byte  = {r_shift, r_mosi_sync};
  assign w_addr_full = {r_addr[22:0], r_mosi_sync};
  assign w_id_next   = (r_byte_cnt == 2'd3) ? 2'd3 : r_byte_cnt + 2'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // A new transfer needs a real CS_n fall with SCK idle low, and only once armed
  always_comb begin
    w_next_state = r_state;
    if (w_cs_n) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall && r_armed && !w_sck) w_next_state = ST_CMD;
        ST_CMD: begin
          if (w_sck_rise && r_bit_cnt == 3'd7) begin
            if (w_cmd_byte == CMD_READ)                                w_next_state = ST_ADDR;
            else if (w_cmd_byte == CMD_RDID || w_cmd_byte == CMD_RDSR) w_next_state = ST_DATA;
            else                                                       w_next_state = ST_IGNORE;
          end
        end
        ST_ADDR: if (w_sck_rise && r_bit_cnt == 3'd7 && r_byte_cnt == 2'd2) w_next_state = ST_DATA;
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 2'd0;
      r_shift     <= 7'd0;
      r_addr      <= 24'd0;
      r_cmd       <= 8'h00;
      r_tx        <= 8'h00;
      r_miso      <= 1'b0;
      r_rd        <= 1'b0;
      r_rd_d      <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_mosi_meta <= i_spi_mosi;
      r_mosi_sync <= r_mosi_meta;
      r_warm      <= {r_warm[0], 1'b1};
      // Arm only once CS_n has been seen high through a synchroniser flushed of reset values
      if (w_cs_rise || (r_warm[1] && w_cs_n)) r_armed <= 1'b1;
      r_busy <= ~w_cs_n;
      r_rd   <= 1'b0;
      r_rd_d <= r_rd;
      if (r_rd_d) r_tx <= i_mem_data;
      if (r_state != ST_DATA) r_miso <= 1'b0;
      if (w_cs_n) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 2'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 2'd0;
          end
          ST_CMD: if (w_sck_rise) begin
            r_shift   <= w_cmd_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_cmd <= w_cmd_byte;
              r_tx  <= (w_cmd_byte == CMD_RDID) ? JEDEC_ID[23:16] : 8'h00;
            end
          end
          ST_ADDR: if (w_sck_rise) begin
            r_addr    <= w_addr_full;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_byte_cnt <= (r_byte_cnt == 2'd2) ? 2'd0 : r_byte_cnt + 2'd1;
              if (r_byte_cnt == 2'd2) begin
                r_rd       <= 1'b1;
                r_mem_addr <= w_addr_full[ADDR_W-1:0];
              end
            end
          end
          ST_DATA: if (w_sck_fall) begin
            r_miso    <= r_tx[7];
            r_tx      <= {r_tx[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            // Last bit of this byte is now on MISO: fetch the next byte a full SCK period early
            if (r_bit_cnt == 3'd7) begin
              if (r_cmd == CMD_READ) begin
                r_rd       <= 1'b1;
                r_mem_addr <= r_mem_addr + 1'b1;
              end else if (r_cmd == CMD_RDID) begin
                r_tx       <= id_byte(w_id_next);
                r_byte_cnt <= w_id_next;
              end else begin
                r_tx <= 8'h00;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_spi_miso_oe = (r_state == ST_DATA);
  assign o_spi_miso    = r_miso & o_spi_miso_oe;
  assign o_mem_rd      = r_rd;
  assign o_mem_addr    = r_mem_addr;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_spi_flash_resp.sv
// tb/tb_spi_flash_resp.sv - directed bench acting as SPI initiator and backing memory
`timescale 1ns/1ps
module tb_spi_flash_resp;

  logic        clk = 1'b0;
  logic        rst, sck, cs_n, mosi;
  logic        miso, oe, mem_rd, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;
  int bad_cnt = 0;
  logic [15:0] rd_log [0:63];

  always #62.5 clk = ~clk;

  spi_flash_resp #(.JEDEC_ID(24'hEF4016), .ADDR_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_spi_sck(sck), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi),
    .o_spi_miso(miso), .o_spi_miso_oe(oe), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
    .i_mem_data(mem_data), .o_busy(busy)
  );

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_addr[7:0] ^ 8'h5A;
      if (rd_cnt < 64) rd_log[rd_cnt] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (oe) oe_cnt = oe_cnt + 1;
    if (miso && !oe) bad_cnt = bad_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic rb);
    mosi = b;
    repeat (4) @(negedge clk);
    rb  = miso;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], rb);
      rx[i] = rb;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_stop();
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    logic       rb;
    logic [7:0] id_exp [0:3];
    int         b_rd, b_oe;
    id_exp[0] = 8'hEF; id_exp[1] = 8'h40; id_exp[2] = 8'h16; id_exp[3] = 8'h00;

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_oe", oe, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // RDID: three ID bytes then zero padding
    b_rd = rd_cnt;
    cs_start();
    chk("busy_cs_low", busy, 1);
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      chk($sformatf("rdid_byte%0d", i), rx, id_exp[i]);
    end
    cs_stop();
    chk("rdid_no_reads", rd_cnt - b_rd, 0);
    chk("busy_cs_high", busy, 0);

    // READ at 0x0010: mem[a] = a[7:0]^5A; the fourth strobe is the lookahead for the
    // byte whose MSB goes out on the closing SCK fall
    b_rd = rd_cnt;
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
    spi_byte(8'h00, rx); chk("read_b0", rx, 8'h4A);
    spi_byte(8'h00, rx); chk("read_b1", rx, 8'h4B);
    spi_byte(8'h00, rx); chk("read_b2", rx, 8'h48);
    cs_stop();
    chk("read_cnt", rd_cnt - b_rd, 4);
    chk("read_a0", rd_log[b_rd], 16'h0010);
    chk("read_a1", rd_log[b_rd+1], 16'h0011);
    chk("read_a2", rd_log[b_rd+2], 16'h0012);
    chk("read_a3", rd_log[b_rd+3], 16'h0013);

    // READ at 0x00FFFF wraps to 0x0000
    b_rd = rd_cnt;
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'hFF, rx); spi_byte(8'hFF, rx);
    spi_byte(8'h00, rx); chk("wrap_b0", rx, 8'hA5);
    spi_byte(8'h00, rx); chk("wrap_b1", rx, 8'h5A);
    cs_stop();
    chk("wrap_cnt", rd_cnt - b_rd, 3);
    chk("wrap_a0", rd_log[b_rd], 16'hFFFF);
    chk("wrap_a1", rd_log[b_rd+1], 16'h0000);

    // Unknown opcode is ignored; RDSR afterwards returns 0x00 with oe driven
    b_rd = rd_cnt; b_oe = oe_cnt;
    cs_start();
    spi_byte(8'hAB, rx);
    spi_byte(8'hFF, rx); chk("ign_b0", rx, 8'h00);
    spi_byte(8'hFF, rx); chk("ign_b1", rx, 8'h00);
    cs_stop();
    chk("ign_oe", oe_cnt - b_oe, 0);
    chk("ign_rd", rd_cnt - b_rd, 0);
    b_oe = oe_cnt;
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx); chk("rdsr_b0", rx, 8'h00);
    spi_byte(8'h00, rx); chk("rdsr_b1", rx, 8'h00);
    cs_stop();
    chk("rdsr_oe", (oe_cnt - b_oe) > 0, 1);

    // Abort mid-address, then a clean RDID
    b_rd = rd_cnt;
    cs_start();
    spi_byte(8'h03, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
    cs_stop();
    cs_start();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, rx);
      chk($sformatf("abort_rdid%0d", i), rx, id_exp[i]);
    end
    cs_stop();
    chk("abort_rd", rd_cnt - b_rd, 0);

    // Reset in the middle of a READ data byte
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, rb);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_oe", oe, 0);
    chk("mid_rst_rd", mem_rd, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    b_rd = rd_cnt; b_oe = oe_cnt;
    repeat (4) @(negedge clk);
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    chk("post_rst_rx", rx, 8'h00);
    chk("post_rst_oe", oe_cnt - b_oe, 0);
    chk("post_rst_rd", rd_cnt - b_rd, 0);
    cs_stop();
    cs_start();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    chk("post_rst_rdid", rx, 8'hEF);
    cs_stop();

    chk("miso_without_oe", bad_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
